// File: rtl/rbcp_axil_bridge.sv
// -----------------------------------------------------------------------------
// rbcp_axil_bridge
//   Translates SiTCP RBCP single-byte read/write requests into AXI4-Lite master
//   transactions of AXI_DATA_WIDTH bits (32 or 64). The byte is replicated on
//   every lane for writes with a one-hot strobe; reads pick one lane of rdata.
//   Error responses are counted in a saturating 16-bit counter and produce no
//   RBCP ack, so the host observes its own RBCP timeout.
//
//   Optional feature macro: RBCP_AXIL_TIMEOUT_EN
//     When defined, a per-transaction cycle counter aborts a hung transaction
//     after TIMEOUT_CYCLES cycles (drops all valid/ready, pulses timeout,
//     counts an error). When undefined the FSM waits indefinitely and timeout
//     stays 0.
//
//   Ports
//     clk, rst_n                 single clock, async active-low reset
//     rbcp_act/addr/wd/we/re     RBCP request from the SiTCP core
//     rbcp_ack                   one-cycle completion pulse
//     rbcp_rd                    read byte, held until the next good read
//     m_axi_*                    AXI4-Lite master (AW, W, B, AR, R channels)
//     busy                       high whenever the FSM is not idle
//     err_cnt                    saturating count of error responses/timeouts
//     timeout                    one-cycle pulse on a timeout abort
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rbcp_axil_bridge #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN     = 1'b1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rbcp_act,
  input  logic [31:0]                 rbcp_addr,
  input  logic [7:0]                  rbcp_wd,
  input  logic                        rbcp_we,
  input  logic                        rbcp_re,
  output logic                        rbcp_ack,
  output logic [7:0]                  rbcp_rd,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready,
  output logic                        busy,
  output logic [15:0]                 err_cnt,
  output logic                        timeout
);

  localparam int NB = AXI_DATA_WIDTH / 8;
  localparam int L  = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    ACK     = 3'd5
  } state_t;

  state_t                    state;
  logic [L-1:0]              lane_r;
  logic [L-1:0]              lane_s;
  logic [AXI_ADDR_WIDTH-1:0] aligned_addr_s;
  logic                      aw_done_s;
  logic                      w_done_s;
  logic                      abort_s;
  logic                      unused_ok;

  // Activity strobe and any address bits above the AXI width carry no meaning here.
  assign unused_ok = rbcp_act ^ (^rbcp_addr);

  // Protection attributes are always unprivileged, secure, data.
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  // For power-of-two NB, NB-1-k is simply the bitwise inverse of k.
  assign lane_s         = BIG_ENDIAN ? ~rbcp_addr[L-1:0] : rbcp_addr[L-1:0];
  assign aligned_addr_s = {rbcp_addr[AXI_ADDR_WIDTH-1:L], {L{1'b0}}};

  // A channel is done once its valid has dropped or is being accepted now.
  assign aw_done_s = ~m_axi_awvalid | m_axi_awready;
  assign w_done_s  = ~m_axi_wvalid  | m_axi_wready;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef RBCP_AXIL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  assign abort_s = (state inside {WR, WR_RESP, RD_ADDR, RD_DATA}) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Cycle counter: zero while idle, counts every cycle spent waiting on the slave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || state == ACK) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Main sequencer: owns the state and every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lane_r        <= '0;
      rbcp_ack      <= 1'b0;
      rbcp_rd       <= 8'h00;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      busy          <= 1'b0;
      err_cnt       <= 16'h0000;
      timeout       <= 1'b0;
    end else begin
      rbcp_ack <= 1'b0;
      timeout  <= 1'b0;
      if (abort_s) begin
        // Dead-slave recovery: abandon the transaction outright.
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        timeout       <= 1'b1;
        err_cnt       <= sat_inc(err_cnt);
        busy          <= 1'b0;
        state         <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // Write has priority; a simultaneous read is dropped.
            if (rbcp_we) begin
              m_axi_awaddr  <= aligned_addr_s;
              m_axi_wdata   <= {NB{rbcp_wd}};
              m_axi_wstrb   <= {{(NB-1){1'b0}}, 1'b1} << lane_s;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              lane_r        <= lane_s;
              busy          <= 1'b1;
              state         <= WR;
            end else if (rbcp_re) begin
              m_axi_araddr  <= aligned_addr_s;
              m_axi_arvalid <= 1'b1;
              lane_r        <= lane_s;
              busy          <= 1'b1;
              state         <= RD_ADDR;
            end else begin
              state <= IDLE;
            end
          end
          WR: begin
            if (m_axi_awready) begin
              m_axi_awvalid <= 1'b0;
            end
            if (m_axi_wready) begin
              m_axi_wvalid <= 1'b0;
            end
            if (aw_done_s && w_done_s) begin
              m_axi_bready <= 1'b1;
              state        <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (m_axi_bvalid) begin
              m_axi_bready <= 1'b0;
              if (m_axi_bresp == 2'b00) begin
                rbcp_ack <= 1'b1;
                state    <= ACK;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                busy    <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          RD_ADDR: begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              m_axi_rready  <= 1'b1;
              state         <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (m_axi_rvalid) begin
              m_axi_rready <= 1'b0;
              if (m_axi_rresp == 2'b00) begin
                rbcp_rd  <= m_axi_rdata[{lane_r, 3'b000} +: 8];
                rbcp_ack <= 1'b1;
                state    <= ACK;
              end else begin
                err_cnt <= sat_inc(err_cnt);
                busy    <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          ACK: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rbcp_axil_bridge.sv
// -----------------------------------------------------------------------------
// tb_rbcp_axil_bridge
//   Two bridge instances share one set of stimulus signals: a 32-bit
//   big-endian one (sel=0) and a 64-bit little-endian one (sel=1). The request
//   strobes are gated by sel so only the selected instance leaves IDLE, and its
//   outputs are muxed onto the o_* view that the slave model and checks use.
//   A table of directed vectors drives a cycle-by-cycle AXI-Lite slave with
//   configurable ready delays and response codes; a back-to-back sequence and
//   (with RBCP_AXIL_TIMEOUT_EN) a dead-slave timeout vector cover the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rbcp_axil_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        rbcp_act, rbcp_we, rbcp_re;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  always #5 clk = ~clk;

  // 32-bit instance outputs
  logic        ack32, awvalid32, wvalid32, bready32, arvalid32, rready32, busy32, tmo32;
  logic [7:0]  rd32;
  logic [31:0] awaddr32, araddr32, wdata32;
  logic [2:0]  awprot32, arprot32;
  logic [3:0]  wstrb32;
  logic [15:0] err32;
  // 64-bit instance outputs
  logic        ack64, awvalid64, wvalid64, bready64, arvalid64, rready64, busy64, tmo64;
  logic [7:0]  rd64;
  logic [31:0] awaddr64, araddr64;
  logic [63:0] wdata64;
  logic [2:0]  awprot64, arprot64;
  logic [7:0]  wstrb64;
  logic [15:0] err64;

  logic we32, re32, we64, re64;
  assign we32 = rbcp_we & ~sel;
  assign re32 = rbcp_re & ~sel;
  assign we64 = rbcp_we & sel;
  assign re64 = rbcp_re & sel;

  rbcp_axil_bridge #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr), .rbcp_wd(rbcp_wd),
    .rbcp_we(we32), .rbcp_re(re32), .rbcp_ack(ack32), .rbcp_rd(rd32),
    .m_axi_awaddr(awaddr32), .m_axi_awprot(awprot32), .m_axi_awvalid(awvalid32), .m_axi_awready(awready),
    .m_axi_wdata(wdata32), .m_axi_wstrb(wstrb32), .m_axi_wvalid(wvalid32), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready32),
    .m_axi_araddr(araddr32), .m_axi_arprot(arprot32), .m_axi_arvalid(arvalid32), .m_axi_arready(arready),
    .m_axi_rdata(rdata[31:0]), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready32),
    .busy(busy32), .err_cnt(err32), .timeout(tmo32)
  );

  rbcp_axil_bridge #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr), .rbcp_wd(rbcp_wd),
    .rbcp_we(we64), .rbcp_re(re64), .rbcp_ack(ack64), .rbcp_rd(rd64),
    .m_axi_awaddr(awaddr64), .m_axi_awprot(awprot64), .m_axi_awvalid(awvalid64), .m_axi_awready(awready),
    .m_axi_wdata(wdata64), .m_axi_wstrb(wstrb64), .m_axi_wvalid(wvalid64), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready64),
    .m_axi_araddr(araddr64), .m_axi_arprot(arprot64), .m_axi_arvalid(arvalid64), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready64),
    .busy(busy64), .err_cnt(err64), .timeout(tmo64)
  );

  // Selected-instance view
  logic        o_ack, o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_busy, o_tmo;
  logic [7:0]  o_rd, o_wstrb;
  logic [31:0] o_awaddr, o_araddr;
  logic [63:0] o_wdata;
  logic [15:0] o_err;
  assign o_ack     = sel ? ack64     : ack32;
  assign o_awvalid = sel ? awvalid64 : awvalid32;
  assign o_wvalid  = sel ? wvalid64  : wvalid32;
  assign o_bready  = sel ? bready64  : bready32;
  assign o_arvalid = sel ? arvalid64 : arvalid32;
  assign o_rready  = sel ? rready64  : rready32;
  assign o_busy    = sel ? busy64    : busy32;
  assign o_tmo     = sel ? tmo64     : tmo32;
  assign o_rd      = sel ? rd64      : rd32;
  assign o_wstrb   = sel ? wstrb64   : {4'h0, wstrb32};
  assign o_awaddr  = sel ? awaddr64  : awaddr32;
  assign o_araddr  = sel ? araddr64  : araddr32;
  assign o_wdata   = sel ? wdata64   : {32'h0, wdata32};
  assign o_err     = sel ? err64     : err32;

  typedef struct {
    logic        sel;
    logic        wr;
    logic        rd_too;   // also raise rbcp_re with the write and again while busy
    logic [31:0] addr;
    logic [7:0]  wd;
    logic [63:0] rdata;
    logic [1:0]  resp;
    int          dly_a;    // AW/AR ready delay in cycles
    int          dly_w;    // W ready delay in cycles
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_wstrb;
    logic [7:0]  e_rd;
    int          e_ack;
    int          e_cyc;
    int          e_an;
    int          e_wn;
    int          e_arn;
    int          e_err;
    int          e_tmo;
  } vec_t;

  vec_t vecs[16];
  int   n_vec;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid  = 1'b0; rvalid = 1'b0;
    bresp   = 2'b00; rresp = 2'b00;
  endtask

  // Issue one request and act as the AXI slave for a fixed 24-cycle window.
  task automatic run_vec(input int i);
    vec_t        v;
    int          aw_n, w_n, ar_n, ack_n, ack_cyc, tmo_n;
    logic [63:0] got_addr, got_wdata, got_wstrb;
    logic [7:0]  rd_ack, rd_fin;
    logic [15:0] err0, err1;
    logic        aw_done, w_done, ar_done, b_done, r_done;
    v = vecs[i];
    aw_n = 0; w_n = 0; ar_n = 0; ack_n = 0; ack_cyc = 0; tmo_n = 0;
    got_addr = 64'h0; got_wdata = 64'h0; got_wstrb = 64'h0; rd_ack = 8'h00;
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; b_done = 1'b0; r_done = 1'b0;
    @(negedge clk);
    sel       = v.sel;
    err0      = v.sel ? err64 : err32;
    slave_idle();
    rbcp_act  = 1'b1;
    rbcp_addr = v.addr;
    rbcp_wd   = v.wd;
    rbcp_we   = v.wr;
    rbcp_re   = ~v.wr | v.rd_too;
    rdata     = v.rdata;
    bresp     = v.resp;
    rresp     = v.resp;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      rbcp_we  = 1'b0;
      rbcp_act = 1'b0;
      rbcp_re  = (c == 1) ? v.rd_too : 1'b0;
      if (o_awvalid) begin aw_n++; got_addr = 64'(o_awaddr); end
      if (o_wvalid)  begin w_n++;  got_wdata = o_wdata; got_wstrb = 64'(o_wstrb); end
      if (o_arvalid) begin ar_n++; got_addr = 64'(o_araddr); end
      if (o_ack)     begin ack_n++; ack_cyc = c; rd_ack = o_rd; end
      if (o_tmo)     tmo_n++;
      awready = (c >= 1 + v.dly_a);
      arready = (c >= 1 + v.dly_a);
      wready  = (c >= 1 + v.dly_w);
      bvalid  = aw_done && w_done && !b_done;
      rvalid  = ar_done && !r_done;
      if (o_awvalid && awready) aw_done = 1'b1;
      if (o_wvalid && wready)   w_done  = 1'b1;
      if (o_arvalid && arready) ar_done = 1'b1;
      if (bvalid && o_bready)   b_done  = 1'b1;
      if (rvalid && o_rready)   r_done  = 1'b1;
    end
    err1   = v.sel ? err64 : err32;
    rd_fin = v.sel ? rd64 : rd32;
    chk($sformatf("v%0d busy_end", i), 64'(o_busy), 64'h0);
    slave_idle();
    chk($sformatf("v%0d ack_count", i), 64'(ack_n), 64'(v.e_ack));
    if (v.e_ack != 0) chk($sformatf("v%0d ack_cycle", i), 64'(ack_cyc), 64'(v.e_cyc));
    chk($sformatf("v%0d addr", i), got_addr, 64'(v.e_addr));
    chk($sformatf("v%0d aw_cycles", i), 64'(aw_n), 64'(v.e_an));
    chk($sformatf("v%0d w_cycles", i), 64'(w_n), 64'(v.e_wn));
    chk($sformatf("v%0d ar_cycles", i), 64'(ar_n), 64'(v.e_arn));
    chk($sformatf("v%0d err_delta", i), 64'(err1 - err0), 64'(v.e_err));
    chk($sformatf("v%0d timeout_pulses", i), 64'(tmo_n), 64'(v.e_tmo));
    if (v.wr) begin
      chk($sformatf("v%0d wdata", i), got_wdata, v.e_wdata);
      chk($sformatf("v%0d wstrb", i), got_wstrb, 64'(v.e_wstrb));
    end else begin
      chk($sformatf("v%0d rd_held", i), 64'(rd_fin), 64'(v.e_rd));
      if (v.e_ack != 0) chk($sformatf("v%0d rd_at_ack", i), 64'(rd_ack), 64'(v.e_rd));
    end
  endtask

  initial begin
    // sel wr rdtoo addr wd rdata resp dA dW | e_addr e_wdata e_wstrb e_rd ack cyc an wn arn err tmo
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_1003, 8'hA5, 64'h0, 2'b00, 0, 0, 32'h0000_1000, 64'h0000_0000_A5A5_A5A5, 8'h01, 8'h00, 1, 3, 1, 1, 0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, 8'h3C, 64'h0, 2'b00, 0, 0, 32'h0000_2000, 64'h0000_0000_3C3C_3C3C, 8'h08, 8'h00, 1, 3, 1, 1, 0, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0001, 8'h5A, 64'h0, 2'b00, 0, 0, 32'h0000_0000, 64'h0000_0000_5A5A_5A5A, 8'h04, 8'h00, 1, 3, 1, 1, 0, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_1002, 8'h00, 64'h0000_0000_1122_3344, 2'b00, 0, 0, 32'h0000_1000, 64'h0, 8'h00, 8'h33, 1, 3, 0, 0, 1, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'h00, 64'h0000_0000_DEAD_BEEF, 2'b00, 0, 0, 32'h0000_0000, 64'h0, 8'h00, 8'hDE, 1, 3, 0, 0, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 8'h00, 64'h0000_0000_CAFE_F00D, 2'b00, 0, 0, 32'hFFFF_FFFC, 64'h0, 8'h00, 8'h0D, 1, 3, 0, 0, 1, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0004, 8'h77, 64'h0, 2'b00, 4, 0, 32'h0000_0004, 64'h0000_0000_7777_7777, 8'h08, 8'h00, 1, 7, 5, 1, 0, 0, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 8'h12, 64'h0, 2'b00, 0, 2, 32'h0000_0008, 64'h0000_0000_1212_1212, 8'h08, 8'h00, 1, 5, 1, 3, 0, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_000C, 8'h00, 64'h0000_0000_0102_0304, 2'b00, 3, 0, 32'h0000_000C, 64'h0, 8'h00, 8'h01, 1, 6, 0, 0, 4, 0, 0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0010, 8'h00, 64'h0000_0000_5566_7788, 2'b10, 0, 0, 32'h0000_0010, 64'h0, 8'h00, 8'h01, 0, 0, 0, 0, 1, 1, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 8'hEE, 64'h0, 2'b11, 0, 0, 32'h0000_0020, 64'h0000_0000_EEEE_EEEE, 8'h08, 8'h00, 0, 0, 1, 1, 0, 1, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_1003, 8'h99, 64'h0, 2'b00, 0, 0, 32'h0000_1000, 64'h0000_0000_9999_9999, 8'h01, 8'h00, 1, 3, 1, 1, 0, 0, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 8'h00, 64'h8877_6655_4433_2211, 2'b00, 0, 0, 32'h0000_0000, 64'h0, 8'h00, 8'h66, 1, 3, 0, 0, 1, 0, 0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h0000_000F, 8'hC3, 64'h0, 2'b00, 0, 0, 32'h0000_0008, 64'hC3C3_C3C3_C3C3_C3C3, 8'h80, 8'h00, 1, 3, 1, 1, 0, 0, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0000_000A, 8'h00, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 0, 0, 32'h0000_0008, 64'h0, 8'h00, 8'h0A, 1, 3, 0, 0, 1, 0, 0};
    n_vec = 15;
`ifdef RBCP_AXIL_TIMEOUT_EN
    // Dead slave: arready never rises inside the window.
    vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0000_0030, 8'h00, 64'h0, 2'b00, 100, 0, 32'h0000_0030, 64'h0, 8'h00, 8'h01, 0, 0, 0, 0, 16, 1, 1};
    n_vec = 16;
`endif

    rst_n = 1'b0; sel = 1'b0;
    rbcp_act = 1'b0; rbcp_we = 1'b0; rbcp_re = 1'b0; rbcp_addr = 32'h0; rbcp_wd = 8'h00;
    rdata = 64'h0;
    slave_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst32 handshakes", 64'({awvalid32, wvalid32, bready32, arvalid32, rready32}), 64'h0);
    chk("rst64 handshakes", 64'({awvalid64, wvalid64, bready64, arvalid64, rready64}), 64'h0);
    chk("rst32 ack_busy_tmo", 64'({ack32, busy32, tmo32}), 64'h0);
    chk("rst64 ack_busy_tmo", 64'({ack64, busy64, tmo64}), 64'h0);
    chk("rst32 rd_err", 64'({rd32, err32}), 64'h0);
    chk("rst64 rd_err", 64'({rd64, err64}), 64'h0);
    chk("rst32 addrs", 64'({awaddr32, araddr32}), 64'h0);
    chk("rst64 addrs", 64'({awaddr64, araddr64}), 64'h0);
    chk("rst32 wdata_wstrb", 64'({wdata32, wstrb32}), 64'h0);
    chk("rst64 wdata", wdata64, 64'h0);
    chk("rst64 wstrb", 64'(wstrb64), 64'h0);
    chk("rst prot", 64'({awprot32, arprot32, awprot64, arprot64}), 64'h0);

    for (int i = 0; i < n_vec; i++) run_vec(i);

    // Back-to-back: write, then a read issued in the first IDLE cycle after ACK.
    @(negedge clk);                     // cycle 0
    sel = 1'b0; slave_idle();
    rbcp_act = 1'b1; rbcp_we = 1'b1; rbcp_addr = 32'h0000_0040; rbcp_wd = 8'h44;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    rdata = 64'h0000_0000_AABB_CCDD;
    @(negedge clk);                     // cycle 1
    rbcp_we = 1'b0; rbcp_act = 1'b0;
    chk("b2b aw_w_valid", 64'({o_awvalid, o_wvalid}), 64'h3);
    @(negedge clk);                     // cycle 2
    chk("b2b bready", 64'(o_bready), 64'h1);
    bvalid = 1'b1;
    @(negedge clk);                     // cycle 3
    bvalid = 1'b0;
    chk("b2b write_ack", 64'(o_ack), 64'h1);
    @(negedge clk);                     // cycle 4
    chk("b2b idle_gap", 64'({o_busy, o_ack}), 64'h0);
    rbcp_re = 1'b1; rbcp_addr = 32'h0000_0041;
    @(negedge clk);                     // cycle 5
    rbcp_re = 1'b0;
    chk("b2b arvalid", 64'(o_arvalid), 64'h1);
    @(negedge clk);                     // cycle 6
    rvalid = 1'b1;
    @(negedge clk);                     // cycle 7
    rvalid = 1'b0;
    chk("b2b read_ack", 64'(o_ack), 64'h1);
    chk("b2b read_byte", 64'(o_rd), 64'hBB);
    @(negedge clk);
    chk("b2b single_ack", 64'({o_ack, o_busy}), 64'h0);
    slave_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
